// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter: FSM state encoding,
// grant_o owner codes and the meaning of the last_grant bit.
package ysyx_22041211_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IFU_REQ = 3'd1,
        ST_IFU_RSP = 3'd2,
        ST_LSU_REQ = 3'd3,
        ST_LSU_RSP = 3'd4
    } arb_state_t;

    // Owner codes; bit 0 is the IFU, bit 1 the LSU, so a one-hot pick maps directly.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IFU  = 2'b01;
    localparam logic [1:0] GRANT_LSU  = 2'b10;

    // Value of last_grant after each owner has been granted.
    localparam logic LAST_IFU = 1'b0;
    localparam logic LAST_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22041211_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins; on contention the
// master that was not granted last time wins.  Output uses the grant_o codes.
module ysyx_22041211_rr_pick
    import ysyx_22041211_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Pure combinational choice from the pending requests and the previous winner.
    always_comb begin
        grant = GRANT_NONE;
        case (req)
            2'b01:   grant = GRANT_IFU;
            2'b10:   grant = GRANT_LSU;
            2'b11:   grant = (last == LAST_LSU) ? GRANT_IFU : GRANT_LSU;
            default: grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Serialises IFU and LSU transactions onto the single memory port.  A whole
// transaction (request handshake, then response handshake) completes before the
// next grant, and every transaction is followed by one IDLE cycle.  Request and
// response paths are combinational pass-throughs selected by the FSM state; the
// only storage is the state register and the last_grant bit.
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_mem_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    input  logic [ADDR_LEN-1:0] ifu_req_addr,
    output logic                ifu_req_ready,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_resp_rdata,
    input  logic                ifu_resp_ready,

    input  logic                lsu_req_valid,
    input  logic [ADDR_LEN-1:0] lsu_req_addr,
    input  logic [DATA_LEN-1:0] lsu_req_wdata,
    input  logic [3:0]          lsu_req_wstrb,
    output logic                lsu_req_ready,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_resp_rdata,
    input  logic                lsu_resp_ready,

    output logic                mem_req_valid,
    output logic [ADDR_LEN-1:0] mem_req_addr,
    output logic [DATA_LEN-1:0] mem_req_wdata,
    output logic [3:0]          mem_req_wstrb,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_resp_rdata,
    output logic                mem_resp_ready,

    output logic [1:0]          grant_o
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_grant;
    logic [1:0] pick;

    ysyx_22041211_rr_pick u_rr_pick (
        .req   ({lsu_req_valid, ifu_req_valid}),
        .last  (last_grant),
        .grant (pick)
    );

    // State register; reset abandons any transaction and returns to IDLE at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember who won the most recent grant; reset favours the IFU on first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= LAST_LSU;
        end else if ((state == ST_IDLE) && (pick != GRANT_NONE)) begin
            last_grant <= (pick == GRANT_LSU) ? LAST_LSU : LAST_IFU;
        end
    end

    // Next-state logic and owner-selected routing of both handshake paths.
    always_comb begin
        state_nxt      = state;
        grant_o        = GRANT_NONE;
        ifu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_rdata = '0;
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        mem_req_wstrb  = 4'b0000;
        mem_resp_ready = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick == GRANT_IFU) begin
                    state_nxt = ST_IFU_REQ;
                end else if (pick == GRANT_LSU) begin
                    state_nxt = ST_LSU_REQ;
                end
            end

            ST_IFU_REQ: begin
                grant_o       = GRANT_IFU;
                mem_req_valid = ifu_req_valid;
                mem_req_addr  = ifu_req_addr;
                ifu_req_ready = mem_req_ready;
                if (ifu_req_valid && mem_req_ready) begin
                    state_nxt = ST_IFU_RSP;
                end
            end

            ST_IFU_RSP: begin
                grant_o        = GRANT_IFU;
                ifu_resp_valid = mem_resp_valid;
                ifu_resp_rdata = mem_resp_rdata;
                mem_resp_ready = ifu_resp_ready;
                if (mem_resp_valid && ifu_resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_LSU_REQ: begin
                grant_o       = GRANT_LSU;
                mem_req_valid = lsu_req_valid;
                mem_req_addr  = lsu_req_addr;
                mem_req_wdata = lsu_req_wdata;
                mem_req_wstrb = lsu_req_wstrb;
                lsu_req_ready = mem_req_ready;
                if (lsu_req_valid && mem_req_ready) begin
                    state_nxt = ST_LSU_RSP;
                end
            end

            ST_LSU_RSP: begin
                grant_o        = GRANT_LSU;
                lsu_resp_valid = mem_resp_valid;
                lsu_resp_rdata = mem_resp_rdata;
                mem_resp_ready = lsu_resp_ready;
                if (mem_resp_valid && lsu_resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter.  Two master drivers issue transactions
// from per-master queues (directed entries first, then random ones); a memory
// model answers the shared port.  Expected responses and expected memory-side
// requests are queued when a master's request is accepted and popped by the
// monitor when the DUT presents them.  The monitor also applies the arbitration
// rules (lone requester wins, contention alternates, one idle cycle between
// owners) and the isolation rules for non-granted masters every cycle.
module tb_ysyx_22041211_mem_arbiter;

    localparam int DATA_LEN = 32;
    localparam int ADDR_LEN = 32;
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_IFU  = 2'b01;
    localparam logic [1:0] G_LSU  = 2'b10;

    logic                clk;
    logic                rst;
    logic                ifu_req_valid;
    logic [ADDR_LEN-1:0] ifu_req_addr;
    logic                ifu_req_ready;
    logic                ifu_resp_valid;
    logic [DATA_LEN-1:0] ifu_resp_rdata;
    logic                ifu_resp_ready;
    logic                lsu_req_valid;
    logic [ADDR_LEN-1:0] lsu_req_addr;
    logic [DATA_LEN-1:0] lsu_req_wdata;
    logic [3:0]          lsu_req_wstrb;
    logic                lsu_req_ready;
    logic                lsu_resp_valid;
    logic [DATA_LEN-1:0] lsu_resp_rdata;
    logic                lsu_resp_ready;
    logic                mem_req_valid;
    logic [ADDR_LEN-1:0] mem_req_addr;
    logic [DATA_LEN-1:0] mem_req_wdata;
    logic [3:0]          mem_req_wstrb;
    logic                mem_req_ready;
    logic                mem_resp_valid;
    logic [DATA_LEN-1:0] mem_resp_rdata;
    logic                mem_resp_ready;
    logic [1:0]          grant_o;

    ysyx_22041211_mem_arbiter #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_rdata (ifu_resp_rdata),
        .ifu_resp_ready (ifu_resp_ready),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wstrb  (lsu_req_wstrb),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_rdata (lsu_resp_rdata),
        .lsu_resp_ready (lsu_resp_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_ready (mem_resp_ready),
        .grant_o        (grant_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          gap;
        int          rwait;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memreq_t;

    txn_t        ifu_txn_q[$];
    txn_t        lsu_txn_q[$];
    logic [31:0] ifu_exp_q[$];
    logic [31:0] lsu_exp_q[$];
    memreq_t     mem_exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];

    int   n_vec = 0;
    int   n_err = 0;
    int   n_grants = 0;
    int   ifu_rand_left = 0;
    int   lsu_rand_left = 0;
    bit   ifu_busy = 1'b0;
    bit   lsu_busy = 1'b0;
    int   mem_rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready
    int   mem_rsp_mode = 0;   // 0 random (plus spurious valids), 1 always, 2 never
    bit   mem_pending = 1'b0;
    logic [31:0] mem_pend_rdata = 32'h0;

    // Monitor history from the previous falling edge.
    bit         prev_rst = 1'b0;
    logic [1:0] prev_grant = G_NONE;
    bit         prev_ifu_v = 1'b0;
    bit         prev_lsu_v = 1'b0;
    bit         exp_last_lsu = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic any_out();
        return |{ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, lsu_req_ready, lsu_resp_valid,
                 lsu_resp_rdata, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb,
                 mem_resp_ready, grant_o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && !(ifu_txn_q.size() == 0 && lsu_txn_q.size() == 0 && !ifu_busy &&
                               !lsu_busy && ifu_rand_left == 0 && lsu_rand_left == 0)) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) timeout("wait_idle");
        repeat (2) @(negedge clk);
    endtask

    // IFU master: fetch requests held until accepted, then wait for the response.
    initial begin
        txn_t t;
        bit   have;
        int   c;
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = 32'h0;
        ifu_resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            ifu_resp_ready = 1'b0;
            ifu_req_addr   = $urandom;
            have = 1'b0;
            if (ifu_txn_q.size() > 0) begin
                ifu_busy = 1'b1;
                t = ifu_txn_q.pop_front();
                have = 1'b1;
            end else if (ifu_rand_left > 0) begin
                ifu_busy = 1'b1;
                ifu_rand_left--;
                t.addr  = 32'h0000_1000 + 32'(4 * $urandom_range(0, 255));
                t.wdata = 32'h0;
                t.wstrb = 4'h0;
                t.gap   = $urandom_range(0, 3);
                t.rwait = $urandom_range(0, 2);
                have = 1'b1;
            end
            if (have) begin
                for (int i = 0; i < t.gap; i++) begin
                    @(posedge clk); #1;
                end
                ifu_req_valid = 1'b1;
                ifu_req_addr  = t.addr;
                do @(negedge clk); while (!ifu_req_ready);
                @(posedge clk); #1;
                ifu_req_valid  = 1'b0;
                ifu_req_addr   = $urandom;
                c = 0;
                ifu_resp_ready = (c >= t.rwait);
                forever begin
                    @(negedge clk);
                    if (!rst) break;
                    if (ifu_resp_valid && ifu_resp_ready) break;
                    @(posedge clk); #1;
                    c++;
                    ifu_resp_ready = (c >= t.rwait);
                end
                ifu_busy = 1'b0;
            end
        end
    end

    // LSU master: loads and stores, same handshake discipline as the IFU.
    initial begin
        txn_t t;
        bit   have;
        int   c;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = 32'h0;
        lsu_req_wdata  = 32'h0;
        lsu_req_wstrb  = 4'h0;
        lsu_resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            lsu_resp_ready = 1'b0;
            lsu_req_addr   = $urandom;
            lsu_req_wdata  = $urandom;
            lsu_req_wstrb  = 4'($urandom);
            have = 1'b0;
            if (lsu_txn_q.size() > 0) begin
                lsu_busy = 1'b1;
                t = lsu_txn_q.pop_front();
                have = 1'b1;
            end else if (lsu_rand_left > 0) begin
                lsu_busy = 1'b1;
                lsu_rand_left--;
                t.addr  = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
                t.wdata = $urandom;
                t.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                t.gap   = $urandom_range(0, 3);
                t.rwait = $urandom_range(0, 2);
                have = 1'b1;
            end
            if (have) begin
                for (int i = 0; i < t.gap; i++) begin
                    @(posedge clk); #1;
                end
                lsu_req_valid = 1'b1;
                lsu_req_addr  = t.addr;
                lsu_req_wdata = t.wdata;
                lsu_req_wstrb = t.wstrb;
                do @(negedge clk); while (!lsu_req_ready);
                @(posedge clk); #1;
                lsu_req_valid  = 1'b0;
                lsu_req_addr   = $urandom;
                lsu_req_wdata  = $urandom;
                lsu_req_wstrb  = 4'($urandom);
                c = 0;
                lsu_resp_ready = (c >= t.rwait);
                forever begin
                    @(negedge clk);
                    if (!rst) break;
                    if (lsu_resp_valid && lsu_resp_ready) break;
                    @(posedge clk); #1;
                    c++;
                    lsu_resp_ready = (c >= t.rwait);
                end
                lsu_busy = 1'b0;
            end
        end
    end

    // Memory model drive side: one outstanding transaction, optional spurious valids.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready = !mem_pending &&
                            (mem_rdy_mode == 1 || (mem_rdy_mode == 0 && $urandom_range(0, 1) == 1));
            if (mem_pending) begin
                mem_resp_valid = (mem_rsp_mode == 1) ||
                                 (mem_rsp_mode == 0 && $urandom_range(0, 1) == 1);
                mem_resp_rdata = mem_pend_rdata;
            end else begin
                mem_resp_valid = (mem_rsp_mode == 0) && ($urandom_range(0, 3) == 0);
                mem_resp_rdata = $urandom;
            end
        end
    end

    // Monitor: scoreboard push/pop, memory bookkeeping, arbitration and isolation rules.
    always @(negedge clk) begin
        memreq_t     m;
        logic [31:0] e;
        logic [1:0]  win;
        logic        viol;
        if (!rst) begin
            check("reset_outputs_zero", 64'(any_out()), 64'h0);
            ifu_exp_q.delete();
            lsu_exp_q.delete();
            mem_exp_q.delete();
            mem_pending  = 1'b0;
            exp_last_lsu = 1'b1;
            prev_rst     = 1'b0;
            prev_grant   = G_NONE;
        end else begin
            if (ifu_req_valid && ifu_req_ready) begin
                ifu_exp_q.push_back(ref_read(ifu_req_addr));
                mem_exp_q.push_back('{ifu_req_addr, 32'h0, 4'h0});
            end
            if (lsu_req_valid && lsu_req_ready) begin
                if (lsu_req_wstrb != 4'h0) begin
                    ref_mem[lsu_req_addr] = merge(ref_read(lsu_req_addr), lsu_req_wdata, lsu_req_wstrb);
                    lsu_exp_q.push_back(32'h0);
                end else begin
                    lsu_exp_q.push_back(ref_read(lsu_req_addr));
                end
                mem_exp_q.push_back('{lsu_req_addr, lsu_req_wdata, lsu_req_wstrb});
            end

            if (mem_resp_valid && mem_resp_ready) begin
                check("mem_resp_outstanding", 64'(mem_pending), 64'h1);
                mem_pending = 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_exp_q.size() == 0) begin
                    check("mem_req_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    m = mem_exp_q.pop_front();
                    check("mem_req_fields", {mem_req_addr, mem_req_wdata[27:0], mem_req_wstrb},
                          {m.addr, m.wdata[27:0], m.wstrb});
                    check("mem_req_wdata_hi", 64'(mem_req_wdata[31:28]), 64'(m.wdata[31:28]));
                end
                if (mem_req_wstrb != 4'h0) begin
                    dev_mem[mem_req_addr] = merge(dev_read(mem_req_addr), mem_req_wdata, mem_req_wstrb);
                    mem_pend_rdata = 32'h0;
                end else begin
                    mem_pend_rdata = dev_read(mem_req_addr);
                end
                mem_pending = 1'b1;
            end

            if (ifu_resp_valid && ifu_resp_ready) begin
                if (ifu_exp_q.size() == 0) begin
                    check("ifu_resp_unexpected", 64'(ifu_resp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = ifu_exp_q.pop_front();
                    check("ifu_resp_rdata", 64'(ifu_resp_rdata), 64'(e));
                end
            end
            if (lsu_resp_valid && lsu_resp_ready) begin
                if (lsu_exp_q.size() == 0) begin
                    check("lsu_resp_unexpected", 64'(lsu_resp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = lsu_exp_q.pop_front();
                    check("lsu_resp_rdata", 64'(lsu_resp_rdata), 64'(e));
                end
            end

            if (prev_rst) begin
                if (prev_grant == G_NONE) begin
                    if (prev_ifu_v || prev_lsu_v) begin
                        if (prev_ifu_v && prev_lsu_v) win = exp_last_lsu ? G_IFU : G_LSU;
                        else                          win = prev_ifu_v ? G_IFU : G_LSU;
                        check("grant_pick", 64'(grant_o), 64'(win));
                        exp_last_lsu = (win == G_LSU);
                        n_grants++;
                    end else begin
                        check("grant_stays_idle", 64'(grant_o), 64'(G_NONE));
                    end
                end else if (grant_o != G_NONE) begin
                    check("grant_no_direct_switch", 64'(grant_o), 64'(prev_grant));
                end
            end

            viol = 1'b0;
            if (grant_o != G_IFU && (ifu_req_ready || ifu_resp_valid || ifu_resp_rdata != 0)) viol = 1'b1;
            if (grant_o != G_LSU && (lsu_req_ready || lsu_resp_valid || lsu_resp_rdata != 0)) viol = 1'b1;
            if (grant_o == G_NONE && (mem_req_valid || mem_req_addr != 0 || mem_req_wdata != 0 ||
                                      mem_req_wstrb != 0 || mem_resp_ready)) viol = 1'b1;
            if (grant_o == G_IFU && mem_req_wstrb != 0) viol = 1'b1;
            if (grant_o == 2'b11) viol = 1'b1;
            check("isolation", 64'(viol), 64'h0);

            prev_rst   = 1'b1;
            prev_grant = grant_o;
            prev_ifu_v = ifu_req_valid;
            prev_lsu_v = lsu_req_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a random soak.
    initial begin
        int k;
        rst = 1'b0;

        // Both masters valid through reset, then continuous contention.
        for (int i = 0; i < 6; i++) begin
            ifu_txn_q.push_back('{32'h0000_1000 + 32'(16 * i), 32'h0, 4'h0, 0, 0});
            lsu_txn_q.push_back('{32'h8000_0020 + 32'(4 * (i % 4)), 32'h0, 4'h0, 0, 0});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_grant", 64'(grant_o), 64'(G_NONE));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("first_cycle_idle", 64'(grant_o), 64'(G_NONE));
        @(negedge clk);
        check("first_grant_ifu", 64'(grant_o), 64'(G_IFU));
        k = 0;
        while (n_grants < 11 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) timeout("contention_grants");
        wait_idle(400);

        // LSU store forwarded unchanged; IFU untouched.
        lsu_txn_q.push_back('{32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 0, 0});
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(grant_o == G_LSU && mem_req_valid) && k < 50);
        if (k >= 50) timeout("store_forward");
        else check("store_fields", {mem_req_addr, mem_req_wstrb, ifu_req_ready},
                   {32'h8000_0010, 4'b0011, 1'b0});
        if (k < 50) check("store_wdata", 64'(mem_req_wdata), 64'hDEAD_BEEF);
        wait_idle(200);

        // Memory stalls the IFU request; a later LSU request must wait its turn.
        mem_rdy_mode = 2;
        ifu_txn_q.push_back('{32'h0000_1040, 32'h0, 4'h0, 0, 0});
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant_o != G_IFU && k < 50);
        if (k >= 50) timeout("stall_grant");
        lsu_txn_q.push_back('{32'h8000_0014, 32'h0, 4'h0, 0, 0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", {grant_o, mem_req_valid, mem_req_addr, ifu_req_ready, lsu_req_ready},
                  {G_IFU, 1'b1, 32'h0000_1040, 1'b0, 1'b0});
        end
        mem_rdy_mode = 0;
        wait_idle(200);

        // LSU holds off its response for three cycles while memory offers data.
        mem_rdy_mode = 1;
        mem_rsp_mode = 1;
        lsu_txn_q.push_back('{32'h8000_0010, 32'h0, 4'h0, 0, 3});
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(lsu_req_valid && lsu_req_ready) && k < 50);
        if (k >= 50) timeout("rsp_hold_accept");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rsp_hold", {grant_o, mem_resp_valid, lsu_resp_valid, mem_resp_ready},
                  {G_LSU, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        check("rsp_deliver", {lsu_resp_valid, lsu_resp_ready, mem_resp_ready}, 3'b111);
        wait_idle(200);

        // Reset while the IFU waits for its response.
        mem_rsp_mode = 2;
        ifu_txn_q.push_back('{32'h0000_1080, 32'h0, 4'h0, 0, 0});
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ifu_req_valid && ifu_req_ready) && k < 50);
        if (k >= 50) timeout("midreset_accept");
        @(posedge clk); #2;
        check("rsp_state_before_reset", 64'(grant_o), 64'(G_IFU));
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {63'h0, any_out()}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_rdy_mode = 0;
        mem_rsp_mode = 0;
        wait_idle(200);
        ifu_txn_q.push_back('{32'h0000_1084, 32'h0, 4'h0, 1, 0});
        lsu_txn_q.push_back('{32'h8000_0018, 32'h0, 4'h0, 1, 1});
        wait_idle(200);

        // Random soak.
        ifu_rand_left = 60;
        lsu_rand_left = 60;
        wait_idle(6000);
        check("ifu_queue_drained", 64'(ifu_exp_q.size()), 64'h0);
        check("lsu_queue_drained", 64'(lsu_exp_q.size()), 64'h0);
        check("mem_queue_drained", 64'(mem_exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
